// File: rtl/comparator_serial.sv
// comparator_serial
//
// Bit-serial magnitude comparator. A request captures operands a and b, then
// the block walks from the MSB down, one bit per clock, and stops at the first
// bit position where the operands differ. The result (gt/lt/eq) and the number
// of bit positions examined are registered and held until the next accept.
//
// Parameters
//   WIDTH   operand width in bits (>= 2)
//   SIGNED  1: two's-complement compare, 0: unsigned compare
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   start_valid  request to compare a against b
//   start_ready  high only while idle; a request is accepted when both are high
//   a, b         operands, sampled on accept
//   busy         high while the scan is in progress
//   done         one-cycle pulse, result valid
//   gt, lt, eq   registered result, exactly one set after a completed compare
//   bits_used    bit positions examined for the last result
module comparator_serial #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     busy,
  output logic                     done,
  output logic                     gt,
  output logic                     lt,
  output logic                     eq,
  output logic [$clog2(WIDTH):0]   bits_used
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("comparator_serial: WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [IdxW-1:0]     idx_q;

  // Bit pair under examination this cycle.
  logic bit_a;
  logic bit_b;
  logic at_msb;
  logic at_lsb;
  logic msb_is_sign;

  always_comb begin
    bit_a       = a_q[idx_q];
    bit_b       = b_q[idx_q];
    at_msb      = (idx_q == IdxMsb);
    at_lsb      = (idx_q == '0);
    // Only the top bit of a signed operand carries negative weight.
    msb_is_sign = SIGNED && at_msb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      gt          <= 1'b0;
      lt          <= 1'b0;
      eq          <= 1'b0;
      bits_used   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid && start_ready) begin
            a_q         <= a;
            b_q         <= b;
            idx_q       <= IdxMsb;
            bits_used   <= '0;
            gt          <= 1'b0;
            lt          <= 1'b0;
            eq          <= 1'b0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state_q     <= StScan;
          end
        end

        StScan: begin
          bits_used <= bits_used + CntW'(1);
          if (bit_a != bit_b) begin
            // A set sign bit marks the smaller operand; anywhere else a set
            // bit marks the larger one.
            if (msb_is_sign) begin
              gt <= bit_b;
              lt <= bit_a;
            end else begin
              gt <= bit_a;
              lt <= bit_b;
            end
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else if (at_lsb) begin
            eq      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q - IdxW'(1);
          end
        end

        StDone: begin
          // Requests seen in this cycle are not accepted; start_ready only
          // rises for the following idle cycle.
          done        <= 1'b0;
          start_ready <= 1'b1;
          state_q     <= StIdle;
        end

        default: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  // Exactly one result flag accompanies every done pulse.
  a_result_onehot : assert property (
    @(posedge clk) disable iff (!rst_n) done |-> $onehot({gt, lt, eq})
  );

  // done is a single-cycle pulse.
  a_done_pulse : assert property (
    @(posedge clk) disable iff (!rst_n) done |=> !done
  );

  // busy and start_ready are never high together.
  a_ready_busy_excl : assert property (
    @(posedge clk) disable iff (!rst_n) !(busy && start_ready)
  );

endmodule

// File: tb/tb_comparator_serial.sv
// Self-checking bench for comparator_serial. Two instances share all inputs:
// one signed, one unsigned. Both scan the same bits, so they finish together.
// A scoreboard queue receives the modelled result at every accept and the
// monitor pops and compares it on every done pulse.
module tb_comparator_serial;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          start_valid;
  logic [W-1:0]  a;
  logic [W-1:0]  b;

  logic          start_ready, busy, done, gt, lt, eq;
  logic [5:0]    bits_used;
  logic          start_ready_u, busy_u, done_u, gt_u, lt_u, eq_u;
  logic [5:0]    bits_used_u;

  comparator_serial #(.WIDTH(W), .SIGNED(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .gt          (gt),
    .lt          (lt),
    .eq          (eq),
    .bits_used   (bits_used)
  );

  comparator_serial #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready_u),
    .a           (a),
    .b           (b),
    .busy        (busy_u),
    .done        (done_u),
    .gt          (gt_u),
    .lt          (lt_u),
    .eq          (eq_u),
    .bits_used   (bits_used_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       gt;
    logic       lt;
    logic       eq;
    logic [5:0] bits;
    logic       ugt;
    logic       ult;
    logic       ueq;
  } exp_t;

  exp_t scoreboard[$];
  int   errors = 0;
  int   checks = 0;
  int   dones  = 0;

  // Directed vectors: operands, expected bits examined, signed and unsigned
  // result as {gt, lt, eq}.
  logic [31:0] va [6] = '{32'd12381, 32'hFFFF_FFFB, 32'hFFFF_FFFA,
                          32'hFFFF_FFFA, 32'd0, 32'd5};
  logic [31:0] vb [6] = '{32'd8484, 32'hFFFF_FFFA, 32'hFFFF_FFFB,
                          32'd5, 32'd0, 32'hFFFF_FFFA};
  logic [5:0]  vk [6] = '{6'd20, 6'd32, 6'd32, 6'd1, 6'd32, 6'd1};
  logic [2:0]  vs [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b100};
  logic [2:0]  vu [6] = '{3'b100, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010};

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    int   k;
    k = 32;
    for (int i = 31; i >= 0; i--) begin
      if (x[i] != y[i]) begin
        k = 32 - i;
        break;
      end
    end
    r.gt   = ($signed(x) > $signed(y));
    r.lt   = ($signed(x) < $signed(y));
    r.eq   = (x == y);
    r.bits = 6'(k);
    r.ugt  = (x > y);
    r.ult  = (x < y);
    r.ueq  = (x == y);
    return r;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest accept.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      dones++;
      checks++;
      if (scoreboard.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got done=1 required no pending request");
      end else begin
        e = scoreboard.pop_front();
        if ({gt, lt, eq, bits_used, gt_u, lt_u, eq_u, bits_used_u, done_u} !==
            {e.gt, e.lt, e.eq, e.bits, e.ugt, e.ult, e.ueq, e.bits, 1'b1}) begin
          errors++;
          $display("FAIL sb_result: got s=%b%b%b bits=%0d u=%b%b%b bits=%0d done_u=%b required s=%b%b%b bits=%0d u=%b%b%b",
                   gt, lt, eq, bits_used, gt_u, lt_u, eq_u, bits_used_u, done_u,
                   e.gt, e.lt, e.eq, e.bits, e.ugt, e.ult, e.ueq);
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Present an operand pair and wait (bounded) for acceptance. Returns #1
  // after the accept edge with start_valid low and a/b scrambled, so a late
  // change of the inputs cannot leak into the result.
  task automatic drive_op(input logic [31:0] oa, input logic [31:0] ob);
    int n;
    @(negedge clk);
    a = oa;
    b = ob;
    start_valid = 1'b1;
    n = 0;
    while (start_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (start_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got start_ready=%b required 1", start_ready);
      start_valid = 1'b0;
      return;
    end
    scoreboard.push_back(model(oa, ob));
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = ~oa;
    b = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", start_ready);
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy_done: got %b required 00", {busy, done});
    end
    checks++;
    if ({gt, lt, eq} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000", {gt, lt, eq});
    end
    checks++;
    if (bits_used !== 6'd0) begin
      errors++;
      $display("FAIL reset_bits_used: got %0d required 0", bits_used);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [31:0] oa, ob;
    exp_t        e;
    int          cyc;
    for (int i = 0; i < 14; i++) begin
      if (i < 6) begin
        oa = va[i];
        ob = vb[i];
      end else begin
        oa = $urandom;
        case ($urandom_range(0, 3))
          0:       ob = oa;
          1:       ob = $urandom;
          default: ob = oa ^ (32'h1 << $urandom_range(0, 31));
        endcase
      end
      e = model(oa, ob);
      drive_op(oa, ob);

      // First cycle after accept: scanning, previous result cleared.
      checks++;
      if ({start_ready, busy, gt, lt, eq, bits_used} !== {1'b0, 1'b1, 3'b000, 6'd0}) begin
        errors++;
        $display("FAIL accept_clear[%0d]: got rdy=%b busy=%b flags=%b bits=%0d required 0 1 000 0",
                 i, start_ready, busy, {gt, lt, eq}, bits_used);
      end

      cyc = 1;
      while (done !== 1'b1 && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      checks++;
      if (cyc != int'(e.bits) + 1) begin
        errors++;
        $display("FAIL latency[%0d]: got done in cycle %0d required cycle %0d",
                 i, cyc, int'(e.bits) + 1);
      end

      if (i < 6) begin
        checks++;
        if ({gt, lt, eq, bits_used, gt_u, lt_u, eq_u} !== {vs[i], vk[i], vu[i]}) begin
          errors++;
          $display("FAIL directed[%0d]: got s=%b bits=%0d u=%b required s=%b bits=%0d u=%b",
                   i, {gt, lt, eq}, bits_used, {gt_u, lt_u, eq_u}, vs[i], vk[i], vu[i]);
        end
      end

      // Result holds into idle; done has dropped.
      @(posedge clk);
      #1;
      checks++;
      if ({done, start_ready, busy, gt, lt, eq, bits_used} !==
          {1'b0, 1'b1, 1'b0, e.gt, e.lt, e.eq, e.bits}) begin
        errors++;
        $display("FAIL hold[%0d]: got done=%b rdy=%b busy=%b flags=%b bits=%0d required 0 1 0 %b %0d",
                 i, done, start_ready, busy, {gt, lt, eq}, bits_used,
                 {e.gt, e.lt, e.eq}, e.bits);
      end
    end
  endtask

  task automatic test_abort();
    int d0;
    @(negedge clk);
    a = 32'd12381;
    b = 32'd8484;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_accept: got busy=%b required 1", busy);
    end
    repeat (3) @(posedge clk);
    // Reset arrives together with a fresh request; reset must win.
    @(negedge clk);
    rst_n = 1'b0;
    start_valid = 1'b1;
    a = 32'd1;
    b = 32'd2;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    checks++;
    if ({start_ready, busy, done, gt, lt, eq, bits_used} !== {1'b1, 1'b0, 1'b0, 3'b000, 6'd0}) begin
      errors++;
      $display("FAIL abort_state: got rdy=%b busy=%b done=%b flags=%b bits=%0d required 1 0 0 000 0",
               start_ready, busy, done, {gt, lt, eq}, bits_used);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d0 = dones;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (dones != d0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses rdy=%b required 0 pulses rdy=1",
               dones - d0, start_ready);
    end
  endtask

  task automatic test_back_to_back();
    int accepts, d0, n, bad_ready;
    accepts   = 0;
    bad_ready = 0;
    n         = 0;
    d0        = dones;
    start_valid = 1'b1;
    while (accepts < 6 && n < 400) begin
      @(negedge clk);
      a = $urandom;
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = $urandom;
        default: b = a ^ (32'h1 << $urandom_range(0, 31));
      endcase
      if (done === 1'b1 && start_ready !== 1'b0) bad_ready++;
      if (start_ready === 1'b1) begin
        scoreboard.push_back(model(a, b));
        accepts++;
      end
      n++;
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    n = 0;
    while (scoreboard.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (dones - d0 != accepts || scoreboard.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses %0d pending required %0d pulses 0 pending",
               dones - d0, scoreboard.size(), accepts);
    end
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL b2b_done_ready: got ready in %0d done cycles required 0", bad_ready);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_abort();
    test_vectors();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comparator_serial.md
COMPARATOR_SERIAL -- requirements
Module: comparator_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter SIGNED, default 1: 1 = two's-complement compare, 0 = unsigned compare.
REQ-003 SHALL use a single clock; reset SHALL be synchronous, active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start_valid  input  1  request to compare a against b.
REQ-007 start_ready  output  1  block can accept a request.
REQ-008 a  input  WIDTH  first operand, sampled on accept.
REQ-009 b  input  WIDTH  second operand, sampled on accept.
REQ-010 busy  output  1  a comparison is in progress.
REQ-011 done  output  1  single-cycle pulse; result valid.
REQ-012 gt  output  1  registered result a > b.
REQ-013 lt  output  1  registered result a < b.
REQ-014 eq  output  1  registered result a == b.
REQ-015 bits_used  output  $clog2(WIDTH)+1  number of bit positions examined for the last result.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-017 start_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in SCAN.
REQ-018 Accept: start_valid && start_ready at a rising edge SHALL capture a and b, set the bit index to WIDTH-1, clear bits_used, and enter SCAN.
REQ-019 start_valid outside IDLE SHALL be ignored; no queuing; a/b changes after accept SHALL not affect the result.
REQ-020 SCAN SHALL examine one bit per cycle, MSB first, incrementing bits_used per bit examined.
REQ-021 Bits equal and index > 0: index decrements; FSM stays in SCAN.
REQ-022 Bits differ at the MSB with SIGNED=1: the operand with MSB=1 is smaller; set lt or gt accordingly; enter DONE.
REQ-023 Bits differ elsewhere (or at MSB with SIGNED=0): the operand with bit=1 is larger; set gt or lt; enter DONE.
REQ-024 Bits equal at index 0: set eq; enter DONE.
REQ-025 Exactly one of gt/lt/eq SHALL be 1 after any completed comparison; early termination is mandatory (no scanning past first differing bit).
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 Latency: with k bits examined (1..WIDTH), done SHALL be high in cycle k+1 after the accept edge; bits_used = k.
REQ-028 gt/lt/eq/bits_used SHALL hold from DONE until the next accept, and SHALL clear to 0 on accept.
REQ-029 Back-to-back: a request presented in the DONE cycle SHALL NOT be accepted; it SHALL be accepted in the following IDLE cycle if still valid.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE; start_ready=1; busy=0, done=0, gt=0, lt=0, eq=0, bits_used=0.
REQ-031 Reset during SCAN or DONE SHALL abort with no done pulse; captured operands are discarded.
REQ-032 Reset SHALL take priority over a simultaneous start_valid.

Verification
REQ-033 a=12381, b=8484 (SIGNED=1) -> gt=1, bits_used=20, done 21 cycles after accept.
REQ-034 a=-5, b=-6 -> gt=1, bits_used=32; a=-6, b=-5 -> lt=1, bits_used=32.
REQ-035 a=-6, b=5: SIGNED=1 -> lt=1, bits_used=1, done 2 cycles after accept; SIGNED=0 -> gt=1, bits_used=1.
REQ-036 a=0, b=0 -> eq=1, bits_used=32; a=5, b=-6 (SIGNED=1) -> gt=1, bits_used=1.
REQ-037 Accept a=12381, b=8484; drop rst_n low for one cycle at cycle 5 -> no done pulse, all outputs 0, start_ready=1 next cycle.
REQ-038 Hold start_valid high continuously with changing a/b -> accepts only in IDLE, one done per accept, results match the operands captured at each accept.
